// File: rtl/PipelineReg.sv
// rtl/PipelineReg.sv - shared pipeline register types, mem_type codes and FSM enum
package PipelineReg;

    localparam logic [3:0] MT_BYTE  = 4'b0001;
    localparam logic [3:0] MT_HALF  = 4'b0011;
    localparam logic [3:0] MT_WORD  = 4'b1111;
    localparam logic [3:0] MT_BYTEU = 4'b1000;
    localparam logic [3:0] MT_HALFU = 4'b1100;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} mem_fsm_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} mem_size_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemToReg;
        logic        MemRead;
        logic        MemWrite;
        logic [3:0]  mem_type;
        logic [31:0] ALUOutput;
        logic [31:0] B;
    } MEM_STATE;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemToReg;
        logic [31:0] ALUOutput;
        logic [31:0] mem_data;
    } WB_STATE;

    // Everything about an in-flight access that must survive the stall.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemToReg;
        logic        we;
        logic [3:0]  mem_type;
        logic [31:0] alu;
        logic [3:0]  be;
        logic [31:0] wdata;
    } MEM_HOLD;

    function automatic mem_size_e size_of(input logic [3:0] mt);
        case (mt)
            MT_BYTE, MT_BYTEU: return SZ_BYTE;
            MT_HALF, MT_HALFU: return SZ_HALF;
            MT_WORD:           return SZ_WORD;
            default:           return SZ_BAD;
        endcase
    endfunction

    function automatic logic is_signed(input logic [3:0] mt);
        return (mt == MT_BYTE) || (mt == MT_HALF);
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane extraction and sign/zero extension
module load_align
    import PipelineReg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_mem_type,
    output logic [31:0] o_data32
);

    logic [31:0] w_shifted;
    logic        w_sext;

    assign w_shifted = i_rdata >> {i_off, 3'b000};
    assign w_sext    = is_signed(i_mem_type);

    always_comb begin
        o_data32 = w_shifted;
        case (size_of(i_mem_type))
            SZ_BYTE: o_data32 = {{24{w_sext & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: o_data32 = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: o_data32 = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: data-memory handshake FSM, store lanes, load align
module mem_stage
    import PipelineReg::*;
#(
    parameter int DMEM_LAT_MAX = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  MEM_STATE    i_mem_state,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output WB_STATE     o_wb_state,
    output logic        o_misalign,
    output logic        o_timeout
);

    localparam int CW = $clog2(DMEM_LAT_MAX + 1);

    mem_fsm_e    r_state;
    logic [CW-1:0] r_cnt;
    MEM_HOLD     r_hold;
    WB_STATE     r_wb;
    logic        r_misalign;
    logic        r_timeout;

    logic        w_is_mem;
    logic [1:0]  w_off;
    mem_size_e   w_size;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_timeout;
    logic [31:0] w_load_data;
    WB_STATE     w_load_wb;

    assign w_is_mem   = i_mem_state.MemRead | i_mem_state.MemWrite;
    assign w_off      = i_mem_state.ALUOutput[1:0];
    assign w_size     = size_of(i_mem_state.mem_type);
    assign w_misalign = w_is_mem && ((w_size == SZ_BAD)
                                  || (w_size == SZ_HALF && w_off[0])
                                  || (w_size == SZ_WORD && w_off != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_mem_state.B;
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{i_mem_state.B[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{i_mem_state.B[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_mem_state.B;
            end
        endcase
    end

    assign w_timeout = (r_state != ST_IDLE) && (r_cnt == CW'(DMEM_LAT_MAX - 1));

    load_align u_load_align (
        .i_rdata    (i_dmem_rdata),
        .i_off      (r_hold.alu[1:0]),
        .i_mem_type (r_hold.mem_type),
        .o_data32   (w_load_data)
    );

    assign w_load_wb = '{pc: r_hold.pc, rd: r_hold.rd, RegWrite: r_hold.RegWrite,
                         MemToReg: r_hold.MemToReg, ALUOutput: r_hold.alu,
                         mem_data: w_load_data};

    // A load completing straight from REQ (gnt with rvalid) also releases the stall,
    // otherwise the held instruction would be re-issued from IDLE.
    always_comb begin
        o_stall = 1'b0;
        case (r_state)
            ST_IDLE: o_stall = w_is_mem & ~w_misalign;
            ST_REQ:  o_stall = ~(i_dmem_gnt & (r_hold.we | i_dmem_rvalid)) & ~w_timeout;
            ST_WAIT: o_stall = ~i_dmem_rvalid & ~w_timeout;
            default: o_stall = 1'b0;
        endcase
    end

    assign o_dmem_req   = (r_state == ST_REQ) & ~i_reset;
    assign o_dmem_we    = r_hold.we;
    assign o_dmem_addr  = {r_hold.alu[31:2], 2'b00};
    assign o_dmem_be    = r_hold.be;
    assign o_dmem_wdata = r_hold.wdata;
    assign o_wb_state   = r_wb;
    assign o_misalign   = r_misalign;
    assign o_timeout    = r_timeout;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_wb       <= '0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_wb       <= '0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_misalign) begin
                        r_misalign <= 1'b1;
                    end else if (w_is_mem) begin
                        r_hold <= '{pc: i_mem_state.pc, rd: i_mem_state.rd,
                                    RegWrite: i_mem_state.RegWrite,
                                    MemToReg: i_mem_state.MemToReg,
                                    we: i_mem_state.MemWrite,
                                    mem_type: i_mem_state.mem_type,
                                    alu: i_mem_state.ALUOutput,
                                    be: w_be, wdata: w_wdata};
                        r_state <= ST_REQ;
                    end else begin
                        r_wb <= '{pc: i_mem_state.pc, rd: i_mem_state.rd,
                                  RegWrite: i_mem_state.RegWrite,
                                  MemToReg: i_mem_state.MemToReg,
                                  ALUOutput: i_mem_state.ALUOutput,
                                  mem_data: 32'h0};
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_timeout) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (i_dmem_gnt) begin
                        if (r_hold.we) begin
                            r_state <= ST_IDLE;
                        end else if (i_dmem_rvalid) begin
                            r_wb    <= w_load_wb;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_timeout) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (i_dmem_rvalid) begin
                        r_wb    <= w_load_wb;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed vectors
module tb_mem_stage;
    import PipelineReg::*;

    logic        clk = 1'b0;
    logic        i_reset;
    MEM_STATE    i_mem_state;
    logic        o_stall, o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_gnt, i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    WB_STATE     o_wb_state;
    logic        o_misalign, o_timeout;

    always #5 clk = ~clk;

    mem_stage #(.DMEM_LAT_MAX(15)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_mem_state  (i_mem_state),
        .o_stall      (o_stall),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_gnt   (i_dmem_gnt),
        .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata (i_dmem_rdata),
        .o_wb_state   (o_wb_state),
        .o_misalign   (o_misalign),
        .o_timeout    (o_timeout)
    );

    int checks = 0;
    int failures = 0;
    WB_STATE exp_q[$];

    int          st_cyc;
    logic        req_seen, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic MEM_STATE mk(input logic [31:0] pc, input logic [4:0] rd,
                                    input logic rw, input logic m2r, input logic mr,
                                    input logic mw, input logic [3:0] mt,
                                    input logic [31:0] alu, input logic [31:0] b);
        return '{pc: pc, rd: rd, RegWrite: rw, MemToReg: m2r, MemRead: mr,
                 MemWrite: mw, mem_type: mt, ALUOutput: alu, B: b};
    endfunction

    function automatic WB_STATE wb(input logic [31:0] pc, input logic [4:0] rd,
                                   input logic m2r, input logic [31:0] alu,
                                   input logic [31:0] md);
        return '{pc: pc, rd: rd, RegWrite: 1'b1, MemToReg: m2r, ALUOutput: alu, mem_data: md};
    endfunction

    // Monitor: every writeback the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (!i_reset && o_wb_state.RegWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_wb actual=%h expected=none", o_wb_state);
            end else begin
                WB_STATE e;
                e = exp_q.pop_front();
                if (o_wb_state !== e) begin
                    failures++;
                    $display("FAIL wb_data actual=%h expected=%h", o_wb_state, e);
                end
            end
        end
    end

    // gw: gnt in REQ cycle gw+1 (or never if <0); rw: rvalid rw cycles after gnt.
    task automatic run_op(input MEM_STATE s, input int gw, input int rw,
                          input logic [31:0] rdata);
        int t;
        bit done;
        t = 0;
        done = 0;
        st_cyc = 0;
        req_seen = 0;
        i_mem_state = s;
        i_dmem_rdata = rdata;
        while (!done) begin
            i_dmem_gnt    = (gw >= 0) && (t == 1 + gw);
            i_dmem_rvalid = (gw >= 0) && (rw >= 0) && (t == 1 + gw + rw);
            #1;
            if (o_dmem_req && !req_seen) begin
                req_seen = 1;
                s_we = o_dmem_we;
                s_addr = o_dmem_addr;
                s_be = o_dmem_be;
                s_wdata = o_dmem_wdata;
            end
            if (!o_stall) done = 1;
            else st_cyc++;
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 40) begin
                checks++;
                failures++;
                $display("FAIL op_bound actual=stall_stuck expected=release");
                done = 1;
            end
        end
        i_mem_state = '0;
        i_dmem_gnt = 0;
        i_dmem_rvalid = 0;
    endtask

    initial begin
        i_reset = 1;
        i_mem_state = '0;
        i_dmem_gnt = 0;
        i_dmem_rvalid = 0;
        i_dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", {31'b0, o_dmem_req}, 32'h0);
        i_reset = 0;
        #1;
        check("reset_wb_rw", {31'b0, o_wb_state.RegWrite}, 32'h0);
        check("reset_wb_alu", o_wb_state.ALUOutput, 32'h0);
        check("reset_flags", {30'b0, o_misalign, o_timeout}, 32'h0);
        check("reset_stall", {31'b0, o_stall}, 32'h0);
        @(posedge clk); #1;

        // ADD
        exp_q.push_back(wb(32'h100, 5'd3, 1'b0, 32'h5, 32'h0));
        run_op(mk(32'h100, 5'd3, 1, 0, 0, 0, 4'h0, 32'h5, 32'h0), -1, -1, 32'h0);
        check("add_stall", st_cyc, 0);

        // SB 0x1003
        run_op(mk(32'h104, 5'd0, 0, 0, 0, 1, MT_BYTE, 32'h1003, 32'hAB), 0, -1, 32'h0);
        check("sb_stall", st_cyc, 1);
        check("sb_req", {31'b0, req_seen}, 32'h1);
        check("sb_we", {31'b0, s_we}, 32'h1);
        check("sb_addr", s_addr, 32'h1000);
        check("sb_be", {28'b0, s_be}, 32'h8);
        check("sb_wdata", s_wdata, 32'hABABABAB);

        // SH 0x1002, gnt after two REQ wait cycles
        run_op(mk(32'h108, 5'd0, 0, 0, 0, 1, MT_HALF, 32'h1002, 32'h1234ABCD), 2, -1, 32'h0);
        check("sh_stall", st_cyc, 3);
        check("sh_be", {28'b0, s_be}, 32'hC);
        check("sh_wdata", s_wdata, 32'hABCDABCD);

        // SW 0x1004
        run_op(mk(32'h10C, 5'd0, 0, 0, 0, 1, MT_WORD, 32'h1004, 32'hCAFEF00D), 0, -1, 32'h0);
        check("sw_addr", s_addr, 32'h1004);
        check("sw_be", {28'b0, s_be}, 32'hF);
        check("sw_wdata", s_wdata, 32'hCAFEF00D);

        // LH / LHU 0x2002
        exp_q.push_back(wb(32'h110, 5'd5, 1'b1, 32'h2002, 32'hFFFF8001));
        run_op(mk(32'h110, 5'd5, 1, 1, 1, 0, MT_HALF, 32'h2002, 32'h0), 0, 2, 32'h80011234);
        check("lh_stall", st_cyc, 3);
        check("lh_we", {31'b0, s_we}, 32'h0);
        check("lh_addr", s_addr, 32'h2000);
        check("lh_no_timeout", {31'b0, o_timeout}, 32'h0);
        exp_q.push_back(wb(32'h114, 5'd6, 1'b1, 32'h2002, 32'h00008001));
        run_op(mk(32'h114, 5'd6, 1, 1, 1, 0, MT_HALFU, 32'h2002, 32'h0), 0, 2, 32'h80011234);

        // LB with gnt and rvalid together
        exp_q.push_back(wb(32'h118, 5'd7, 1'b1, 32'h2001, 32'hFFFFFFF6));
        run_op(mk(32'h118, 5'd7, 1, 1, 1, 0, MT_BYTE, 32'h2001, 32'h0), 1, 0, 32'h1234F678);
        check("lb_same_cycle_stall", st_cyc, 2);

        // LBU 0x2003, LW 0x2000
        exp_q.push_back(wb(32'h11C, 5'd8, 1'b1, 32'h2003, 32'h0000009A));
        run_op(mk(32'h11C, 5'd8, 1, 1, 1, 0, MT_BYTEU, 32'h2003, 32'h0), 0, 1, 32'h9A000000);
        exp_q.push_back(wb(32'h120, 5'd9, 1'b1, 32'h2000, 32'hDEADBEEF));
        run_op(mk(32'h120, 5'd9, 1, 1, 1, 0, MT_WORD, 32'h2000, 32'h0), 0, 0, 32'hDEADBEEF);
        check("lw_stall", st_cyc, 1);

        // Misaligned LW 0x3001
        run_op(mk(32'h124, 5'd10, 1, 1, 1, 0, MT_WORD, 32'h3001, 32'h0), 0, 0, 32'h0);
        check("mis_lw_req", {31'b0, req_seen}, 32'h0);
        check("mis_lw_stall", st_cyc, 0);
        check("mis_lw_pulse", {31'b0, o_misalign}, 32'h1);
        check("mis_lw_rw", {31'b0, o_wb_state.RegWrite}, 32'h0);
        @(posedge clk); #1;
        check("mis_pulse_end", {31'b0, o_misalign}, 32'h0);

        // Misaligned LH 0x2001 and undefined mem_type
        run_op(mk(32'h128, 5'd11, 1, 1, 1, 0, MT_HALF, 32'h2001, 32'h0), 0, 0, 32'h0);
        check("mis_lh_pulse", {31'b0, o_misalign}, 32'h1);
        run_op(mk(32'h12C, 5'd12, 1, 1, 1, 0, 4'b0101, 32'h2000, 32'h0), 0, 0, 32'h0);
        check("mis_type_pulse", {31'b0, o_misalign}, 32'h1);
        check("mis_type_req", {31'b0, req_seen}, 32'h0);

        // Timeout: gnt, no rvalid
        run_op(mk(32'h130, 5'd13, 1, 1, 1, 0, MT_WORD, 32'h2000, 32'h0), 0, -1, 32'h0);
        check("tmo_stall_cycles", st_cyc, 15);
        check("tmo_pulse", {31'b0, o_timeout}, 32'h1);
        check("tmo_rw", {31'b0, o_wb_state.RegWrite}, 32'h0);
        i_dmem_rvalid = 1;
        i_dmem_rdata = 32'h55555555;
        #1;
        check("late_rvalid_stall", {31'b0, o_stall}, 32'h0);
        check("late_rvalid_req", {31'b0, o_dmem_req}, 32'h0);
        @(posedge clk); #1;
        i_dmem_rvalid = 0;
        check("tmo_pulse_end", {31'b0, o_timeout}, 32'h0);
        check("late_rvalid_rw", {31'b0, o_wb_state.RegWrite}, 32'h0);

        // Reset while in WAIT
        i_mem_state = mk(32'h134, 5'd14, 1, 1, 1, 0, MT_WORD, 32'h2000, 32'h0);
        @(posedge clk); #1;
        i_dmem_gnt = 1;
        @(posedge clk); #1;
        i_dmem_gnt = 0;
        #1;
        check("wait_stall", {31'b0, o_stall}, 32'h1);
        i_reset = 1;
        #1;
        check("rst_req_during", {31'b0, o_dmem_req}, 32'h0);
        @(posedge clk); #1;
        i_reset = 0;
        i_mem_state = '0;
        i_dmem_rvalid = 1;
        #1;
        check("rst_req_after", {31'b0, o_dmem_req}, 32'h0);
        check("rst_stall_after", {31'b0, o_stall}, 32'h0);
        @(posedge clk); #1;
        i_dmem_rvalid = 0;
        check("rst_no_wb", {31'b0, o_wb_state.RegWrite}, 32'h0);

        // Recovery after reset
        exp_q.push_back(wb(32'h200, 5'd1, 1'b0, 32'hA5A5A5A5, 32'h0));
        run_op(mk(32'h200, 5'd1, 1, 0, 0, 0, 4'h0, 32'hA5A5A5A5, 32'h0), -1, -1, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 SHALL have one clock and a synchronous, active-high reset: i_clk and i_reset, as named below.
- REQ-002 SHALL accept parameter DMEM_LAT_MAX, default 15, meaning the maximum number of gnt/rvalid wait cycles before o_timeout asserts.
- REQ-003 SHALL have the following ports:
  - i_clk  in  1  clock; all state updates on the rising edge.
  - i_reset  in  1  synchronous, active-high reset.
  - i_mem_state  in  PipelineReg::MEM_STATE  EX-stage output; RegWrite=0 and MemRead=MemWrite=0 denotes a bubble.
  - o_stall  out  1  freeze upstream; i_mem_state is held stable while this is high.
  - o_dmem_req  out  1  data-memory request.
  - o_dmem_we  out  1  1=store, 0=load.
  - o_dmem_addr  out  32  word address: {ALUOutput[31:2],2'b00}.
  - o_dmem_be  out  4  byte enables.
  - o_dmem_wdata  out  32  lane-replicated store data.
  - i_dmem_gnt  in  1  request accepted.
  - i_dmem_rvalid  in  1  load data valid.
  - i_dmem_rdata  in  32  load data.
  - o_wb_state  out  PipelineReg::WB_STATE  registered fields: pc, rd, RegWrite, MemToReg, ALUOutput, mem_data.
  - o_misalign  out  1  one-cycle pulse on a misaligned access.
  - o_timeout  out  1  one-cycle pulse when the wait limit is exceeded.

Function
- REQ-004 mem_type decode: 0001 byte signed (LB/SB), 0011 half signed (LH/SH), 1111 word, 1000 byte unsigned (LBU), 1100 half unsigned (LHU); any other code with MemRead|MemWrite SHALL be treated as misaligned.
- REQ-005 FSM states SHALL be IDLE, REQ, WAIT; the transitions are given in REQ-006 to REQ-011.
- REQ-006 In IDLE, a non-memory op SHALL register into o_wb_state next cycle (latency 1) with mem_data=0 and o_stall=0.
- REQ-007 In IDLE, an aligned memory op SHALL latch addr/be/wdata/rd/pc/control into a hold register, assert o_stall, and go to REQ.
- REQ-008 Misaligned cases: half with addr[0]=1, or word with addr[1:0]!=0.
  - no request, no stall;
  - o_wb_state.RegWrite=0;
  - o_misalign=1 next cycle.
- REQ-009 In REQ, o_dmem_req=1 with stable outputs until i_dmem_gnt.
  - store + gnt: o_stall=0 that cycle, wb bubble next cycle, go to IDLE;
  - load + gnt: go to WAIT.
- REQ-010 In WAIT, o_stall SHALL stay 1 until i_dmem_rvalid; on rvalid, o_stall=0 that cycle, wb valid next cycle with mem_data=aligned/extended rdata, go to IDLE.
- REQ-011 Timeout: a wait counter SHALL count cycles in REQ+WAIT; on reaching DMEM_LAT_MAX:
  - o_timeout pulse;
  - op dropped as a bubble;
  - o_stall=0 that cycle;
  - go to IDLE;
  - a late rvalid in IDLE is ignored.
- REQ-012 o_stall SHALL be combinational: (IDLE & aligned memop) | (REQ & ~(gnt & we)) | (WAIT & ~rvalid), each term forced to 0 on timeout.
- REQ-013 Store lanes, with off=addr[1:0]:
  - byte: wdata={4{b}}, be=0001<<off;
  - half: wdata={2{h}}, be=0011<<off;
  - word: wdata=B, be=1111.
- REQ-014 Load extract: rdata>>(8*off), then per mem_type take bits [7:0] or [15:0] or [31:0], sign- or zero-extended to 32 bits.
- REQ-015 While o_stall=1, o_wb_state SHALL carry RegWrite=0 every cycle.
- REQ-016 Simultaneous gnt and rvalid in REQ for a load SHALL complete the load in that cycle.
- REQ-017 o_dmem_req SHALL be 0 whenever i_reset=1.

Reset
- REQ-018 On i_reset (synchronous): state=IDLE, counter=0, hold register=0, all o_wb_state fields=0, o_misalign=0, o_timeout=0.
- REQ-019 Reset mid-REQ/WAIT SHALL abandon the op with no writeback, and o_dmem_req SHALL be 0 from the cycle after the reset edge.

Structure
- REQ-020 MEM_STATE, WB_STATE, the mem_type constants, and the FSM enum SHALL live in package PipelineReg.
- REQ-021 Extraction and extension SHALL be one combinational sub-module, load_align (in: rdata, off, mem_type; out: data32).

Verification
- REQ-022 Bench SHALL cover these directed scenarios:
  - ADD result ALUOutput=0x00000005, RegWrite=1 -> o_wb_state.ALUOutput=0x5 next cycle, o_stall never high.
  - SB addr=0x1003, B=0x000000AB, gnt in the first REQ cycle -> be=1000, wdata=0xABABABAB, addr=0x1000; o_stall high for exactly 1 cycle.
  - LH addr=0x2002, rdata=0x8001xxxx, gnt in REQ cycle 1, rvalid 2 cycles later -> mem_data=0xFFFF8001; LHU of the same -> 0x00008001.
  - LW addr=0x3001 -> no o_dmem_req, o_misalign pulse, wb RegWrite=0.
  - Load with gnt but rvalid never arriving, DMEM_LAT_MAX=15 -> o_timeout after 15 cycles, stall drops, later rvalid ignored.
  - i_reset asserted in WAIT -> next cycle IDLE, req=0, no wb write.
